instr_fill_ctrl: RTL and testbench

- Miss-handling and line-fill controller that sits directly upstream of the 2-way instruction L1 (InstrL1). It is the only driver of the L1 write port.
- On an L1 miss it stalls the fetch stage and fetches the 8-word line from backing memory, one word per request. It writes each word into the L1, then replays the access so the fetch completes as a hit.

---
 rtl/instr_fill_ctrl.sv | 132 +++++++++++++
 tb/tb_instr_fill_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fill_ctrl.sv
// Line-fill controller in front of the 2-way instruction L1.
// On a miss it stalls fetch, streams the 8-word line in ascending order into the L1, then replays the access.
module instr_fill_ctrl #(
  parameter int ADDR_SIZE      = 14,
  parameter int WORD_SIZE      = 32,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_rd,
  input  logic [ADDR_SIZE-1:0] cpu_addr,
  output logic [WORD_SIZE-1:0] cpu_data,
  output logic                 cpu_stall,
  output logic [ADDR_SIZE-1:0] l1_addr,
  output logic                 l1_we,
  output logic [WORD_SIZE-1:0] l1_wdata,
  input  logic [WORD_SIZE-1:0] l1_dout,
  input  logic                 l1_hit,
  output logic                 mem_rd,
  output logic [ADDR_SIZE-1:0] mem_addr,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_rvalid
);

  localparam int WORD_OFFSET_BITS = $clog2(WORDS_PER_LINE);
  localparam int LINE_BITS        = ADDR_SIZE - WORD_OFFSET_BITS;
  localparam logic [WORD_OFFSET_BITS-1:0] LAST_OFFSET = WORD_OFFSET_BITS'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    WRITE  = 3'd3,
    REPLAY = 3'd4
  } state_t;

  state_t                      state_r;
  logic [WORD_OFFSET_BITS-1:0] fill_cnt_r;
  logic [LINE_BITS-1:0]        miss_line_r;   // tag+index of the line being filled
  logic [WORD_OFFSET_BITS-1:0] next_cnt_s;
  logic                        miss_s;

  assign miss_s     = cpu_rd & ~l1_hit;
  assign next_cnt_s = fill_cnt_r + {{(WORD_OFFSET_BITS-1){1'b0}}, 1'b1};
  assign cpu_data   = l1_dout;

  // Fill sequencer: state, fill counter and all registered request/write outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      fill_cnt_r  <= {WORD_OFFSET_BITS{1'b0}};
      miss_line_r <= {LINE_BITS{1'b0}};
      l1_we       <= 1'b0;
      l1_wdata    <= {WORD_SIZE{1'b0}};
      mem_rd      <= 1'b0;
      mem_addr    <= {ADDR_SIZE{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (miss_s) begin
            miss_line_r <= cpu_addr[ADDR_SIZE-1:WORD_OFFSET_BITS];
            fill_cnt_r  <= {WORD_OFFSET_BITS{1'b0}};
            mem_rd      <= 1'b1;
            mem_addr    <= {cpu_addr[ADDR_SIZE-1:WORD_OFFSET_BITS], {WORD_OFFSET_BITS{1'b0}}};
            state_r     <= REQ;
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          mem_rd  <= 1'b0;
          state_r <= WAIT;
        end
        // Only a return while waiting is accepted; stray valids elsewhere are ignored.
        WAIT: begin
          if (mem_rvalid) begin
            l1_wdata <= mem_rdata;
            l1_we    <= 1'b1;
            state_r  <= WRITE;
          end else begin
            state_r <= WAIT;
          end
        end
        WRITE: begin
          l1_we <= 1'b0;
          if (fill_cnt_r == LAST_OFFSET) begin
            state_r <= REPLAY;
          end else begin
            fill_cnt_r <= next_cnt_s;
            mem_rd     <= 1'b1;
            mem_addr   <= {miss_line_r, next_cnt_s};
            state_r    <= REQ;
          end
        end
        // A replay that still misses is re-detected as an ordinary miss from IDLE.
        REPLAY: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          l1_we   <= 1'b0;
          mem_rd  <= 1'b0;
        end
      endcase
    end
  end

  // L1 address routing and fetch stall.
  always_comb begin
    l1_addr   = cpu_addr;
    cpu_stall = 1'b1;
    case (state_r)
      IDLE: begin
        l1_addr   = cpu_addr;
        cpu_stall = miss_s;
      end
      REPLAY: begin
        l1_addr   = cpu_addr;
        cpu_stall = ~l1_hit;
      end
      REQ, WAIT, WRITE: begin
        l1_addr   = {miss_line_r, fill_cnt_r};
        cpu_stall = 1'b1;
      end
      default: begin
        l1_addr   = cpu_addr;
        cpu_stall = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fill_ctrl.sv
// Scoreboard bench for instr_fill_ctrl with a 2-way, 16-set InstrL1 model and a variable-latency memory.
module tb_instr_fill_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd;
  logic [13:0] cpu_addr;
  logic [31:0] cpu_data;
  logic        cpu_stall;
  logic [13:0] l1_addr;
  logic        l1_we;
  logic [31:0] l1_wdata;
  logic [31:0] l1_dout;
  logic        l1_hit;
  logic        mem_rd;
  logic [13:0] mem_addr;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_rvalid = 1'b0;

  always #5 clk = ~clk;

  instr_fill_ctrl dut (
    .clk(clk), .reset(reset), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr),
    .cpu_data(cpu_data), .cpu_stall(cpu_stall), .l1_addr(l1_addr),
    .l1_we(l1_we), .l1_wdata(l1_wdata), .l1_dout(l1_dout), .l1_hit(l1_hit),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [13:0] a);
    return {a, 4'hC, ~a};
  endfunction

  // Scoreboard queues
  logic [13:0] mem_q[$];
  logic [45:0] wr_q[$];
  logic [31:0] data_q[$];

  task automatic push_fill(input logic [13:0] a);
    logic [13:0] line;
    for (int i = 0; i < 8; i++) begin
      line = {a[13:3], 3'(i)};
      mem_q.push_back(line);
      wr_q.push_back({line, mem_word(line)});
    end
  endtask

  // Backing memory: fixed latency per request, random stray valids when idle
  int          lat = 1;
  int          mcnt = 0;
  logic [13:0] pend_addr = 14'h0;
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0BAD_F00D;
    if (reset) begin
      mcnt = 0;
    end else begin
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_word(pend_addr);
        end
      end else if ($urandom_range(3, 0) == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
      end
      if (mem_rd) begin
        mcnt      = lat;
        pend_addr = mem_addr;
      end
    end
  end

  // InstrL1 model: 16 sets x 2 ways x 8 words, LRU flips on the offset-7 write
  logic        l1_v [2][16];
  logic [6:0]  l1_t [2][16];
  logic [31:0] l1_d [2][16][8];
  logic        lru  [16];
  logic        l1_w;
  int          last_way = 0;
  logic [3:0]  l1_set;
  logic [6:0]  l1_tg;
  logic [2:0]  l1_off;
  logic        hit0, hit1;

  assign l1_set  = l1_addr[6:3];
  assign l1_tg   = l1_addr[13:7];
  assign l1_off  = l1_addr[2:0];
  assign hit0    = l1_v[0][l1_set] && (l1_t[0][l1_set] == l1_tg);
  assign hit1    = l1_v[1][l1_set] && (l1_t[1][l1_set] == l1_tg);
  assign l1_hit  = hit0 | hit1;
  assign l1_dout = hit0 ? l1_d[0][l1_set][l1_off] : (hit1 ? l1_d[1][l1_set][l1_off] : 32'h0);

  always @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < 16; s++) begin
        l1_v[0][s] = 1'b0;
        l1_v[1][s] = 1'b0;
        lru[s]     = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (l1_we && !reset) begin
      l1_w = lru[l1_set];
      l1_t[l1_w][l1_set] = l1_tg;
      l1_v[l1_w][l1_set] = 1'b1;
      l1_d[l1_w][l1_set][l1_off] = l1_wdata;
      if (l1_off == 3'd7) begin
        lru[l1_set] = ~lru[l1_set];
        last_way    = int'(l1_w);
      end
    end
  end

  // Output monitor, well clear of both clock edges
  int mem_rd_cnt = 0;
  int wr_cnt     = 0;
  int done_cnt   = 0;
  always @(negedge clk) begin
    logic [45:0] e;
    #2;
    if (!reset) begin
      if (mem_rd) begin
        mem_rd_cnt++;
        if (mem_q.size() == 0) check("mem_rd_extra", 32'(mem_rd), 32'd0);
        else check("mem_addr", 32'(mem_addr), 32'(mem_q.pop_front()));
      end
      if (l1_we) begin
        wr_cnt++;
        if (wr_q.size() == 0) begin
          check("l1_we_extra", 32'(l1_we), 32'd0);
        end else begin
          e = wr_q.pop_front();
          check("l1_addr", 32'(l1_addr), 32'(e[45:32]));
          check("l1_wdata", l1_wdata, e[31:0]);
        end
      end
      if (cpu_rd && !cpu_stall) begin
        done_cnt++;
        if (data_q.size() == 0) check("fetch_extra", 32'(cpu_stall), 32'd1);
        else check("cpu_data", cpu_data, data_q.pop_front());
      end
    end
  end

  task automatic wait_done(input int base, input int exp_cycles, input int sw_at, input logic [13:0] sw_addr);
    int n = 0;
    while (done_cnt == base && n < 1000) begin
      @(posedge clk);
      n++;
      if (n == sw_at) begin
        #1;
        cpu_addr = sw_addr;
      end
    end
    check("fetch_done", 32'(done_cnt - base), 32'd1);
    check("cycles", 32'(n), 32'(exp_cycles));
    #1;
    cpu_rd = 1'b0;
    check("mem_q_left", 32'(mem_q.size()), 32'd0);
    check("wr_q_left", 32'(wr_q.size()), 32'd0);
  endtask

  task automatic fetch(input logic [13:0] a, input bit exp_miss, input int exp_cycles,
                       input int sw_at, input logic [13:0] sw_addr);
    int base = done_cnt;
    cpu_rd   = 1'b1;
    cpu_addr = a;
    data_q.push_back(mem_word(sw_at > 0 ? sw_addr : a));
    if (exp_miss) push_fill(a);
    if (sw_at > 0) push_fill(sw_addr);
    #1;
    check("stall_first", 32'(cpu_stall), 32'(exp_miss));
    check("l1_addr_idle", 32'(l1_addr), 32'(a));
    wait_done(base, exp_cycles, sw_at, sw_addr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w1;
    int n;
    int base;
    int wbase;
    reset    = 1'b1;
    cpu_rd   = 1'b0;
    cpu_addr = 14'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_l1_we", 32'(l1_we), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_l1_wdata", l1_wdata, 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);

    // Cold miss, latency 1, then the whole line hits
    lat = 1;
    fetch(14'h0123, 1'b1, 8 * (1 + 2) + 2, 0, 14'h0);
    for (int i = 0; i < 8; i++) fetch(14'h0120 + 14'(i), 1'b0, 1, 0, 14'h0);

    // Same index, different tag: fills land in opposite ways
    lat = 5;
    fetch(14'h0100, 1'b1, 8 * (5 + 2) + 2, 0, 14'h0);
    w1 = last_way;
    lat = 20;
    fetch(14'h2100, 1'b1, 8 * (20 + 2) + 2, 0, 14'h0);
    check("opp_way", 32'(last_way), 32'(1 - w1));
    fetch(14'h0105, 1'b0, 1, 0, 14'h0);
    fetch(14'h2106, 1'b0, 1, 0, 14'h0);
    fetch(14'h0127, 1'b0, 1, 0, 14'h0);

    // Fetch address moves during WAIT: old line completes, replay misses and refills
    lat = 5;
    fetch(14'h0040, 1'b1, 16 * (5 + 2) + 4, 3, 14'h3FFF);
    fetch(14'h0044, 1'b0, 1, 0, 14'h0);
    fetch(14'h3FF9, 1'b0, 1, 0, 14'h0);

    // Reset while waiting on the 4th word, then a full refill
    lat   = 5;
    base  = mem_rd_cnt;
    wbase = wr_cnt;
    cpu_rd   = 1'b1;
    cpu_addr = 14'h0563;
    push_fill(14'h0563);
    n = 0;
    while (mem_rd_cnt < base + 4 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("rd_before_rst", 32'(mem_rd_cnt - base), 32'd4);
    check("wr_before_rst", 32'(wr_cnt - wbase), 32'd3);
    reset = 1'b1;
    mem_q.delete();
    wr_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("post_rst_we", 32'(l1_we), 32'd0);
    check("post_rst_rd", 32'(mem_rd), 32'd0);
    check("post_rst_stall", 32'(cpu_stall), 32'd1);
    wbase = wr_cnt;
    data_q.push_back(mem_word(14'h0563));
    push_fill(14'h0563);
    wait_done(done_cnt, 8 * (5 + 2) + 2, 0, 14'h0);
    check("refill_writes", 32'(wr_cnt - wbase), 32'd8);
    fetch(14'h0560, 1'b0, 1, 0, 14'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
